// File: rtl/dram_req_ctrl.sv
// dram_req_ctrl: single-outstanding load/store sequencer in front of the data RAM.
// Optional out-of-window rejection is built when DRAM_BOUNDS_CHECK_EN is defined.
module dram_req_ctrl #(
    parameter logic [15:0] ADDR_LO     = 16'd16,
    parameter logic [15:0] ADDR_HI     = 16'd6144,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("dram_req_ctrl: WAIT_CYCLES must be >= 1");
    end

    if (ADDR_LO > ADDR_HI) begin : g_bad_window
        $error("dram_req_ctrl: ADDR_LO must not exceed ADDR_HI");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [15:0]     r_mem_addr;
    logic [15:0]     r_mem_din;
    logic [15:0]     r_rdata;
    logic            w_legal;
    logic            w_acc_start;
    logic            w_err_start;
    logic            w_acc_done;

`ifdef DRAM_BOUNDS_CHECK_EN
    logic            r_err;

    // Unsigned window compare on the address offered at the accept edge
    assign w_legal = (req_addr >= ADDR_LO) && (req_addr <= ADDR_HI);
`else
    assign w_legal = 1'b1;
`endif

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

`ifdef DRAM_BOUNDS_CHECK_EN
    assign rsp_err   = r_err;
`else
    assign rsp_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and single-cycle event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_acc_start = 1'b0;
        w_err_start = 1'b0;
        w_acc_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_legal) begin
                        w_acc_start = 1'b1;
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_err_start = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_acc_done  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Access window counter: loaded on accept, counts down to the capture edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_acc_start) begin
            r_cnt <= CNT_INIT;
        end else if ((r_state == S_ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Latch the request direction whenever a request is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
        end else if (w_acc_start || w_err_start) begin
            r_we <= req_we;
        end
    end

    // Registered RAM pins: driven for the whole window, cleared on the capture edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
        end else if (w_acc_start) begin
            r_mem_read  <= ~req_we;
            r_mem_write <= req_we;
            r_mem_addr  <= req_addr;
            r_mem_din   <= req_we ? req_wdata : 16'h0000;
        end else if (w_acc_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
        end
    end

    // Response data: RAM output for loads, zero for stores and rejects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_acc_done) begin
            r_rdata <= r_we ? 16'h0000 : mem_dout;
        end else if (w_err_start) begin
            r_rdata <= '0;
        end
    end

`ifdef DRAM_BOUNDS_CHECK_EN
    // Error flag: set by a rejected request, cleared by a completed access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc_done) begin
            r_err <= 1'b0;
        end else if (w_err_start) begin
            r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Directed scoreboard bench for dram_req_ctrl.
// Two instances (WAIT_CYCLES=1 and 3) share request inputs, selected by sel.
module tb_dram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_ready, b_req_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [15:0] a_rsp_rdata, b_rsp_rdata;
    logic        a_rsp_err, b_rsp_err;
    logic        a_mem_read, b_mem_read;
    logic        a_mem_write, b_mem_write;
    logic [15:0] a_mem_addr, b_mem_addr;
    logic [15:0] a_mem_din, b_mem_din;
    logic [15:0] a_mem_dout, b_mem_dout;

    logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
    logic [15:0] rsp_rdata, mem_addr, mem_din;

    bit [15:0] a_ram [0:65535];
    bit [15:0] b_ram [0:65535];

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sbq[$];
    int   ntests = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

    dram_req_ctrl #(.WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_dout(a_mem_dout)
    );

    dram_req_ctrl #(.WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    // RAM models: combinational read, commit on negedge
    assign a_mem_dout = a_mem_read ? a_ram[a_mem_addr] : 16'h0000;
    assign b_mem_dout = b_mem_read ? b_ram[b_mem_addr] : 16'h0000;

    always @(negedge clk) begin
        if (a_mem_write) a_ram[a_mem_addr] <= a_mem_din;
        if (b_mem_write) b_ram[b_mem_addr] <= b_mem_din;
    end

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign mem_read  = sel ? b_mem_read  : a_mem_read;
    assign mem_write = sel ? b_mem_write : a_mem_write;
    assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    assign mem_din   = sel ? b_mem_din   : a_mem_din;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic we, input logic [15:0] addr,
                          input logic [15:0] data, input logic [15:0] er,
                          input logic ee, input bit push);
        rsp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
        req_addr  = 16'h5A5A;
        req_wdata = 16'hA5A5;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            sbq.push_back(e);
        end
    endtask

    task automatic access(input logic we, input logic [15:0] addr,
                          input logic [15:0] data, input int w);
        for (int k = 0; k < w; k++) begin
            chk("acc_mem_read", mem_read, !we);
            chk("acc_mem_write", mem_write, we);
            chk("acc_mem_addr", mem_addr, addr);
            chk("acc_mem_din", mem_din, we ? data : 16'h0000);
            chk("acc_rsp_valid", rsp_valid, 0);
            chk("acc_req_ready", req_ready, 0);
            step();
        end
    endtask

    task automatic take_rsp();
        rsp_t e;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_req_ready", req_ready, 0);
        chk("rsp_mem_rw", {mem_read, mem_write}, 0);
        chk("rsp_mem_addr", mem_addr, 0);
        chk("sb_pending", sbq.size(), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic xact(input logic we, input logic [15:0] addr,
                        input logic [15:0] data, input int w,
                        input logic [15:0] er);
        accept(we, addr, data, er, 1'b0, 1'b1);
        access(we, addr, data, w);
        take_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        b_ram[6144] = 16'h1234;
        b_ram[200]  = 16'h0AAA;
        a_ram[15]   = 16'h00F5;
        a_ram[16]   = 16'h0016;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mem_rw", {mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // store then read-after-write, WAIT_CYCLES=1
        xact(1'b1, 16'd100, 16'hBEEF, 1, 16'h0000);
        xact(1'b0, 16'd100, 16'h0000, 1, 16'hBEEF);
        step();
        chk("rdata_retained", rsp_rdata, 16'hBEEF);

        // long window, top of range, WAIT_CYCLES=3
        sel = 1'b1;
        xact(1'b0, 16'd6144, 16'h0000, 3, 16'h1234);
        sel = 1'b0;

        // backpressure with a new request pending
        accept(1'b0, 16'd100, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        access(1'b0, 16'd100, 16'h0000, 1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'd101;
        req_wdata = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 16'hBEEF);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_mem_write", mem_write, 0);
            step();
        end
        take_rsp();
        accept(1'b1, 16'd101, 16'h5555, 16'h0000, 1'b0, 1'b1);
        access(1'b1, 16'd101, 16'h5555, 1);
        take_rsp();
        xact(1'b0, 16'd101, 16'h0000, 1, 16'h5555);

`ifdef DRAM_BOUNDS_CHECK_EN
        accept(1'b0, 16'd15, 16'h0000, 16'h0000, 1'b1, 1'b1);
        take_rsp();
        accept(1'b1, 16'd6145, 16'h9999, 16'h0000, 1'b1, 1'b1);
        take_rsp();
        chk("err_no_write", a_ram[6145], 0);
        accept(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1);
        take_rsp();
        accept(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
        take_rsp();
`else
        xact(1'b0, 16'd15, 16'h0000, 1, 16'h00F5);
`endif
        xact(1'b0, 16'd16, 16'h0000, 1, 16'h0016);

        // reset during a store before its commit negedge
        sel = 1'b1;
        accept(1'b1, 16'd200, 16'h7777, 16'h0000, 1'b0, 1'b0);
        chk("pre_rst_mem_write", mem_write, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_mem_write", mem_write, 0);
        chk("async_mem_addr", mem_addr, 0);
        chk("async_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        xact(1'b0, 16'd200, 16'h0000, 3, 16'h0AAA);
        chk("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dram_req_ctrl.md
Name: dram_req_ctrl

Overview:
- Request controller that sits directly upstream of the data RAM and is its only driver.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Sequences the RAM's read/write/addr/d_in pins for a fixed access window, then returns read data or a write acknowledge over a valid/ready response channel.
- Optionally rejects addresses outside the RAM's populated window.

Parameters:
- ADDR_LO, 16, lowest legal RAM word address, inclusive (2 x port count with PORT_EXPONENT=3).
- ADDR_HI, 6144, highest legal RAM word address, inclusive.
- WAIT_CYCLES, 1, cycles mem_read/mem_write are held per access; must be >= 1, 0 is an elaboration error.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  16  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  16  load data; 0 for stores and errors.
- rsp_err  out  1  request rejected, no RAM access made.
- mem_read  out  1  to RAM read.
- mem_write  out  1  to RAM write; RAM commits on negedge clk.
- mem_addr  out  16  to RAM addr.
- mem_din  out  16  to RAM d_in.
- mem_dout  in  16  from RAM d_out; combinational, 0 when mem_read=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
  - Latched request registers and wait counter cleared.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1; all mem_* outputs 0.
  - On posedge with req_valid=1, latch req_we, req_addr and req_wdata.
  - Latched address legal: go to ACCESS and load the counter with WAIT_CYCLES-1.
  - Latched address illegal (feature on only): go to RESP with rsp_err=1 and rsp_rdata=0. No mem_* pin toggles.
- ACCESS:
  - req_ready=0; mem_addr=latched addr.
  - Load: mem_read=1, mem_write=0, mem_din=0.
  - Store: mem_write=1, mem_read=0, mem_din=latched wdata.
  - Pins are registered outputs and stay stable for exactly WAIT_CYCLES cycles.
  - Counter decrements each posedge. At the posedge where the counter is 0, rsp_rdata is captured from mem_dout for loads, or set to 0 for stores. rsp_err=0; go to RESP.
  - All mem_* outputs return to 0 in the same edge.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1 is sampled on a posedge, then go to IDLE.
  - rsp_rdata and rsp_err keep their values afterwards until the next capture.
  - A request offered in RESP is not accepted that cycle.
- Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 posedges. An error response arrives after 1 posedge.
- Max throughput: one request per WAIT_CYCLES+2 cycles with rsp_ready held high.
- Store data is committed at the first negedge of ACCESS. Later negedges rewrite the same value (harmless).
- A read-after-write to the same address returns the new data: the store has completed before IDLE.
- Request inputs are sampled only at the accept edge. Changes to them during ACCESS/RESP are ignored.
- Reset mid-ACCESS: mem_write drops asynchronously. A store whose negedge has not yet occurred is lost; no response is issued.
- Range check is unsigned: legal iff ADDR_LO <= addr <= ADDR_HI. 16'hFFFF is illegal, 0 is illegal.

Optional Feature:
- Macro: DRAM_BOUNDS_CHECK_EN.
- Defined: out-of-window requests are rejected as described, with rsp_err=1 and no RAM access.
- Undefined: the range compare is not built. Every request goes through ACCESS with any address, and rsp_err is tied to 0.

Test Plan:
- Reset, then store addr=100, wdata=16'hBEEF, WAIT_CYCLES=1 -> mem_write=1 and mem_addr=100 for exactly one cycle; rsp_valid two posedges after accept; rsp_rdata=0, rsp_err=0.
- Load addr=100 after the previous store -> mem_read=1 for one cycle; rsp_rdata=16'hBEEF.
- WAIT_CYCLES=3, load addr=6144 (preloaded 16'h1234) -> mem_read high for 3 cycles; rsp_rdata=16'h1234 after 4 posedges.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 and a new request pending -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; new request accepted in the first IDLE cycle after the handshake.
- Feature on: load addr=15, then store addr=6145 -> each gives rsp_err=1, rsp_rdata=0, mem_read=mem_write=0 throughout. Feature off: the same load drives mem_addr=15 and rsp_err=0.
- Assert rst_n low mid-ACCESS of a store to addr=200 before its negedge -> mem_write drops immediately, no rsp_valid; a later load of addr=200 returns the old value.
